// File: rtl/downlink_tx_pkg.sv
// Shared constants and types for the telemetry downlink transmitter.
package downlink_tx_pkg;

  localparam int unsigned IO_ADDR_W     = 9;
  localparam int unsigned IO_DATA_W     = 15;
  localparam int unsigned DL_FRAME_BITS = 32;

  localparam logic [IO_ADDR_W-1:0] CH_DNLNK0 = 9'o034;
  localparam logic [IO_ADDR_W-1:0] CH_DNLNK1 = 9'o035;

  typedef logic [IO_DATA_W-1:0] reg_t;

  typedef struct packed {
    logic                 wr_en;
    logic [IO_ADDR_W-1:0] addr;
  } ctrl_t;

  typedef enum logic [1:0] {
    DL_IDLE  = 2'd0,
    DL_SHIFT = 2'd1,
    DL_GAP   = 2'd2
  } dl_state_t;

  // One downlink word: data followed by its odd-parity bit.
  function automatic logic [IO_DATA_W:0] dl_word(input reg_t w);
    return {w, ~^w};
  endfunction

endpackage

// File: rtl/downlink_tx_if.sv
// IO channel bus between the CPU write path (master) and IO responders (slave).
interface downlink_tx_if;
  import downlink_tx_pkg::*;

  logic                 io_wr_en;
  logic [IO_ADDR_W-1:0] io_addr;
  reg_t                 io_wr_data;
  reg_t                 io_rd_data;
  logic                 io_addr_hit;

  modport master (
    output io_wr_en, io_addr, io_wr_data,
    input  io_rd_data, io_addr_hit
  );

  modport slave (
    input  io_wr_en, io_addr, io_wr_data,
    output io_rd_data, io_addr_hit
  );
endinterface

// File: rtl/downlink_bit_timer.sv
// Modulo-CLKS_PER_BIT bit-time counter; strobe marks the first cycle of each bit-time.
module downlink_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_l,
  input  logic clear,
  input  logic start,
  input  logic en,
  output logic tick_c,
  output logic strobe
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  assign tick_c = en & (count == LAST);

  // clear wins over start so an abort never leaves a stray strobe behind
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      count  <= '0;
      strobe <= 1'b0;
    end else if (clear) begin
      count  <= '0;
      strobe <= 1'b0;
    end else if (start) begin
      count  <= '0;
      strobe <= 1'b1;
    end else if (en) begin
      count  <= tick_c ? '0 : count + CW'(1);
      strobe <= tick_c;
    end else begin
      strobe <= 1'b0;
    end
  end

endmodule

// File: rtl/downlink_tx.sv
// Telemetry downlink transmitter: buffers a channel 034/035 word pair and
// shifts it out as a 32-bit parity-protected serial frame.
module downlink_tx
  import downlink_tx_pkg::*;
#(
  parameter int unsigned          CLKS_PER_BIT = 16,
  parameter int unsigned          GAP_BITS     = 2,
  parameter logic [IO_ADDR_W-1:0] CH_WORD0     = CH_DNLNK0,
  parameter logic [IO_ADDR_W-1:0] CH_WORD1     = CH_DNLNK1
) (
  input  logic         clk,
  input  logic         rst_l,
  downlink_tx_if.slave bus,
  input  logic         dl_enable,
  output logic         dl_bit,
  output logic         dl_strobe,
  output logic         dl_frame,
  output logic         downrupt,
  output logic         overrun
);

  localparam logic [1:0] S_IDLE  = DL_IDLE;
  localparam logic [1:0] S_SHIFT = DL_SHIFT;
  localparam logic [1:0] S_GAP   = DL_GAP;

  localparam int unsigned BW       = $clog2(DL_FRAME_BITS);
  localparam logic [BW-1:0] BIT_LAST = BW'(DL_FRAME_BITS - 1);
  localparam int unsigned GAP_CYC  = GAP_BITS * CLKS_PER_BIT;
  localparam int unsigned GW       = $clog2(GAP_CYC);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

  logic [1:0]               state, state_n;
  logic [DL_FRAME_BITS-1:0] shifter, shifter_n;
  logic [BW-1:0]            bit_cnt, bit_cnt_n;
  logic [GW-1:0]            gap_cnt, gap_cnt_n;
  reg_t                     hold0, hold1;
  logic                     full0, full0_n, full1, full1_n, overrun_n;
  logic                     wr0_c, wr1_c, pair_ready_c, load_c, shift_done_c, tick_c;

  assign wr0_c        = bus.io_wr_en & (bus.io_addr == CH_WORD0);
  assign wr1_c        = bus.io_wr_en & (bus.io_addr == CH_WORD1);
  assign pair_ready_c = full0 & full1;

  assign bus.io_addr_hit = (bus.io_addr == CH_WORD0) | (bus.io_addr == CH_WORD1);
  assign bus.io_rd_data  = (bus.io_addr == CH_WORD0) ? hold0 :
                           (bus.io_addr == CH_WORD1) ? hold1 : '0;

  downlink_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk    (clk),
    .rst_l  (rst_l),
    .clear  (shift_done_c | ~dl_enable),
    .start  (load_c),
    .en     (state == S_SHIFT),
    .tick_c (tick_c),
    .strobe (dl_strobe)
  );

  // Next-state, buffer flags and shifter update
  always_comb begin
    state_n      = state;
    shifter_n    = shifter;
    bit_cnt_n    = bit_cnt;
    gap_cnt_n    = gap_cnt;
    full0_n      = full0;
    full1_n      = full1;
    overrun_n    = overrun;
    load_c       = 1'b0;
    shift_done_c = 1'b0;
    if (!dl_enable) begin
      state_n   = S_IDLE;
      full0_n   = 1'b0;
      full1_n   = 1'b0;
      overrun_n = 1'b0;
    end else begin
      case (state)
        S_IDLE:  load_c = pair_ready_c;
        S_SHIFT: begin
          if (tick_c) begin
            if (bit_cnt == BIT_LAST) begin
              shift_done_c = 1'b1;
              state_n      = S_GAP;
              gap_cnt_n    = '0;
            end else begin
              shifter_n = {shifter[DL_FRAME_BITS-2:0], 1'b0};
              bit_cnt_n = bit_cnt + BW'(1);
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state_n = S_IDLE;
            load_c  = pair_ready_c;
          end else begin
            gap_cnt_n = gap_cnt + GW'(1);
          end
        end
        default: state_n = S_IDLE;
      endcase
      // shifter takes the pre-write holding values; a same-edge write re-arms its flag
      if (load_c) begin
        state_n   = S_SHIFT;
        shifter_n = {dl_word(hold0), dl_word(hold1)};
        bit_cnt_n = '0;
        full0_n   = 1'b0;
        full1_n   = 1'b0;
      end
      if (wr0_c) full0_n = 1'b1;
      if (wr1_c) full1_n = 1'b1;
      if ((wr0_c | wr1_c) & pair_ready_c & ~load_c) overrun_n = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state    <= S_IDLE;
      shifter  <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      hold0    <= '0;
      hold1    <= '0;
      full0    <= 1'b0;
      full1    <= 1'b0;
      overrun  <= 1'b0;
      dl_bit   <= 1'b0;
      dl_frame <= 1'b0;
      downrupt <= 1'b0;
    end else begin
      state    <= state_n;
      shifter  <= shifter_n;
      bit_cnt  <= bit_cnt_n;
      gap_cnt  <= gap_cnt_n;
      full0    <= full0_n;
      full1    <= full1_n;
      overrun  <= overrun_n;
      if (wr0_c) hold0 <= bus.io_wr_data;
      if (wr1_c) hold1 <= bus.io_wr_data;
      dl_bit   <= (state_n == S_SHIFT) & shifter_n[DL_FRAME_BITS-1];
      dl_frame <= (state_n == S_SHIFT);
      downrupt <= load_c;
    end
  end

endmodule
